// File: rtl/ifu_idu_queue_pkg.sv
// ifu_idu_queue_pkg: shared fetch-path widths and the IFU->IDU payload type
package ifu_idu_queue_pkg;
    localparam int CPU_WIDTH = 32;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [CPU_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0] inst;
    } fetch_t;
endpackage

// File: rtl/ifu_idu_queue_if.sv
// ifu_idu_queue_if: IFU-side and IDU-side handshakes plus EXU flush and occupancy
interface ifu_idu_queue_if #(
    parameter int CPU_WIDTH = ifu_idu_queue_pkg::CPU_WIDTH,
    parameter int CNT_W = $clog2(ifu_idu_queue_pkg::DEPTH) + 1
);
    logic in_valid;
    logic in_ready;
    logic [CPU_WIDTH-1:0] in_pc;
    logic [CPU_WIDTH-1:0] in_inst;
    logic out_valid;
    logic out_ready;
    logic [CPU_WIDTH-1:0] out_pc;
    logic [CPU_WIDTH-1:0] out_inst;
    logic flush;
    logic [CNT_W-1:0] count;
    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush,
        input in_ready, out_valid, out_pc, out_inst, count
    );
    modport slave (
        input in_valid, in_pc, in_inst, out_ready, flush,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/ifu_idu_queue_ptr.sv
// ifu_idu_queue_ptr: wrapping buffer pointer with increment and clear
module ifu_idu_queue_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk)
        if (rst || clr) ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/ifu_idu_queue.sv
// ifu_idu_queue: DEPTH-entry elastic IFU->IDU instruction buffer with flush
module ifu_idu_queue
    import ifu_idu_queue_pkg::*;
#(
    parameter int CPU_WIDTH = ifu_idu_queue_pkg::CPU_WIDTH,
    parameter int DEPTH = ifu_idu_queue_pkg::DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic rst,
    ifu_idu_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    logic [2*CPU_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [2*CPU_WIDTH-1:0] head;
    logic push, pop;
    // handshakes depend only on occupancy, so no comb path from out_ready to in_ready
    assign q.in_ready = cnt != CNT_W'(DEPTH);
    assign q.out_valid = cnt != '0;
    assign push = q.in_valid & q.in_ready & ~q.flush;
    assign pop = q.out_valid & q.out_ready & ~q.flush;
    assign q.count = cnt;
    assign head = mem[rd_ptr];
    assign q.out_pc = q.out_valid ? head[2*CPU_WIDTH-1:CPU_WIDTH] : '0;
    assign q.out_inst = q.out_valid ? head[CPU_WIDTH-1:0] : '0;
    ifu_idu_queue_ptr #(.W(AW)) u_wr (.clk(clk), .rst(rst), .inc(push), .clr(q.flush), .ptr(wr_ptr));
    ifu_idu_queue_ptr #(.W(AW)) u_rd (.clk(clk), .rst(rst), .inc(pop), .clr(q.flush), .ptr(rd_ptr));
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {q.in_pc, q.in_inst};
    always_ff @(posedge clk)
        if (rst || q.flush) cnt <= '0;
        else cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
endmodule

// File: tb/tb_ifu_idu_queue.sv
// tb_ifu_idu_queue: scoreboard bench for the IFU->IDU instruction queue
module tb_ifu_idu_queue;
    import ifu_idu_queue_pkg::*;
    localparam int D = 4;
    localparam int CW = $clog2(D) + 1;
    logic clk = 0;
    logic rst = 1;
    logic chk_en = 0;
    int n_chk = 0;
    int n_fail = 0;
    fetch_t exp_q[$];
    ifu_idu_queue_if #(.CPU_WIDTH(32), .CNT_W(CW)) bus ();
    ifu_idu_queue #(.CPU_WIDTH(32), .DEPTH(D), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .q(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask
    // reference model: expected entries enter on accepted pushes, leave on accepted pops
    always @(posedge clk) begin
        int sz;
        sz = exp_q.size();
        if (rst || bus.flush) exp_q.delete();
        else begin
            if (bus.out_ready && sz > 0) void'(exp_q.pop_front());
            if (bus.in_valid && sz < D) exp_q.push_back('{pc: bus.in_pc, inst: bus.in_inst});
        end
    end
    always @(negedge clk) if (chk_en) begin
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != D));
        chk("count", 32'(bus.count), 32'(exp_q.size()));
        chk("count_le_depth", 32'(bus.count <= CW'(D)), 32'd1);
        if (exp_q.size() != 0) begin
            chk("out_pc", bus.out_pc, exp_q[0].pc);
            chk("out_inst", bus.out_inst, exp_q[0].inst);
        end else begin
            chk("out_pc_masked", bus.out_pc, 32'd0);
            chk("out_inst_masked", bus.out_inst, 32'd0);
        end
    end
    initial begin
        bus.in_valid = 0;
        bus.in_pc = 0;
        bus.in_inst = 0;
        bus.out_ready = 0;
        bus.flush = 0;
        cyc();
        cyc();
        rst = 0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk_en = 1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1;
            bus.in_pc = 32'(i * 4);
            bus.in_inst = 32'h1000 + 32'(i);
            cyc();
        end
        bus.in_pc = 32'h10;
        bus.in_inst = 32'h1004;
        #1;
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_head_pc", bus.out_pc, 32'h0);
        cyc();
        cyc();
        #1;
        chk("fifth_rejected_count", 32'(bus.count), 32'd4);
        bus.out_ready = 1;
        #1;
        chk("full_pop_count", 32'(bus.count), 32'd4);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        #1;
        chk("after_pop_count", 32'(bus.count), 32'd3);
        chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
        chk("after_pop_pc", bus.out_pc, 32'h4);
        cyc();
        bus.in_valid = 0;
        #1;
        chk("push_pop_count", 32'(bus.count), 32'd3);
        chk("push_pop_pc", bus.out_pc, 32'h8);
        repeat (5) cyc();
        chk("drained_count", 32'(bus.count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1;
            bus.in_pc = 32'h100 + 32'(i * 4);
            bus.in_inst = 32'h2000 + 32'(i);
            if (i > 0) begin
                #1;
                chk("stream_count", 32'(bus.count), 32'd1);
                chk("stream_inst", bus.out_inst, 32'h2000 + 32'(i - 1));
            end
            cyc();
        end
        bus.in_valid = 0;
        cyc();
        chk("stream_empty", 32'(bus.count), 32'd0);
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1;
            bus.in_pc = 32'h200 + 32'(i * 4);
            bus.in_inst = 32'h3000 + 32'(i);
            cyc();
        end
        bus.in_pc = 32'h20c;
        bus.in_inst = 32'hdead;
        bus.flush = 1;
        #1;
        chk("pre_flush_count", 32'(bus.count), 32'd3);
        cyc();
        bus.flush = 0;
        bus.in_valid = 0;
        #1;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_out_inst", bus.out_inst, 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1;
        bus.in_pc = 32'h300;
        bus.in_inst = 32'h3333;
        cyc();
        bus.in_valid = 0;
        bus.out_ready = 1;
        #1;
        chk("post_flush_inst", bus.out_inst, 32'h3333);
        cyc();
        bus.flush = 1;
        bus.in_valid = 1;
        repeat (3) begin
            cyc();
            chk("held_flush_count", 32'(bus.count), 32'd0);
        end
        bus.flush = 0;
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid = 1'($urandom_range(1));
            bus.out_ready = 1'($urandom_range(1));
            bus.flush = $urandom_range(99) < 2;
            bus.in_pc = $urandom;
            bus.in_inst = $urandom;
            cyc();
        end
        bus.in_valid = 0;
        bus.flush = 0;
        bus.out_ready = 1;
        repeat (D + 1) cyc();
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("final_rst_count", 32'(bus.count), 32'd0);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_idu_queue.md
# ifu_idu_queue

Parametrised elastic instruction queue between the instruction fetch unit (IFU) and the instruction decode unit (IDU). It replaces the single-entry IFU→IDU pipeline register with a DEPTH-entry circular buffer. The buffer uses a valid/ready handshake on both sides and a one-cycle flush on branch or jump redirect from EXU. This lets IFU run ahead of IDU stalls without losing fetched instructions.

## Interface
Parameters:
- CPU_WIDTH, 32: width of PC and instruction payload.
- DEPTH, 4: number of entries. Must be a power of two and ≥2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  IFU presents an instruction.
- in_ready  out  1  queue can accept; equals !full.
- in_pc  in  CPU_WIDTH  PC of the incoming instruction.
- in_inst  in  CPU_WIDTH  incoming instruction word.
- out_valid  out  1  head entry is valid for IDU.
- out_ready  in  1  IDU consumes the head.
- out_pc  out  CPU_WIDTH  head PC; 0 when out_valid=0.
- out_inst  out  CPU_WIDTH  head instruction; 0 when out_valid=0.
- flush  in  1  branch_en | jump_en from EXU; discards all contents.
- count  out  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × (2·CPU_WIDTH) register array, plus wr_ptr and rd_ptr (log2(DEPTH) bits each) and a count register.
- Pointers wrap naturally modulo DEPTH.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- Push writes mem[wr_ptr] and increments wr_ptr.
- Pop increments rd_ptr.
- count update: count += push − pop. A simultaneous push and pop leaves count unchanged.
- full = (count == DEPTH). empty = (count == 0).
- in_ready = !full. It is registered-state derived only and never depends on out_ready, so there is no combinational in→out path.
- A push while full is impossible by construction. When full, in_valid is held and IFU is stalled.
- out_valid = !empty.
- out_pc/out_inst = mem[rd_ptr] when out_valid, else 0. This preserves the zero-bubble convention on the IDU side.
- Flush has priority over everything.
  - wr_ptr, rd_ptr and count go to 0 at the next edge.
  - Any push or pop in the flush cycle is discarded.
  - Array contents are not cleared; they are masked by out_valid.
- Reset (rst=1 at an edge), including mid-stream: same effect as flush.
  - Outputs after reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=0.
- No state machine beyond the pointers and count. Occupancy is the only state.

## Timing
- Latency from push to out_valid is 1 cycle: an entry written at edge N is visible at the head after edge N when the queue was empty.
- There is no same-cycle bypass from in to out.
- Throughput is 1 push and 1 pop per cycle sustained, including when count=DEPTH−1 or count=1.
- At full, a simultaneous pop does not raise in_ready in the same cycle. in_ready rises the cycle after the pop, so the full-state bubble costs 1 cycle.
- At empty with in_valid=1 and out_ready=1: the push occurs and the pop does not, because out_valid=0.
- Flush asserted at edge N: out_valid=0, count=0 and in_ready=1 after edge N. A push is accepted again from the cycle after flush deasserts.
- Flush held for several cycles: the queue stays empty and every in_valid is dropped.

## Structure
- The shared package carries CPU_WIDTH and a packed fetch-payload struct {pc, inst} used by IFU, this queue and IDU.
- One natural sub-module: ifu_idu_queue_ptr, a wrapping pointer register with inc and clr inputs, instantiated twice.
- Occupancy logic and output masking stay in the top module.

## Test plan
- Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, count=0, out_pc=out_inst=0.
- Fill with DEPTH=4 and out_ready=0: push PCs 0x00, 0x04, 0x08, 0x0C → count=4, in_ready=0. A 5th in_valid is not accepted. Raising out_ready then yields the order 0x00, 0x04, 0x08, 0x0C.
- Streaming: in_valid=out_ready=1 for 20 cycles with incrementing inst → out_inst follows in_inst delayed by 1 cycle, count=1 steady, and pointers wrap with no loss.
- Flush mid-stream: count=3, assert flush with in_valid=1 → next cycle count=0, out_valid=0, out_inst=0. The flush-cycle instruction never appears at the output.
- Simultaneous push/pop at full: count=4, out_ready=1 → count stays at 4 for that cycle, with in_ready=0. in_ready=1 the following cycle and count=3.
- Random in_valid and out_ready (50%) over 10k cycles against a scoreboard model, with random flush at 2%: output order matches, and count never exceeds DEPTH.
